instr_fetch_unit: RTL and testbench

Initiator side of the instruction-memory interface. Owns the program counter and drives a word address to the combinational instruction ROM, which returns the word in the same cycle. Registers each fetched word, with its PC, into a valid/ready output stage for the decode stage. Handles absolute jumps (j/jal) locally and accepts redirects (branch, jr, exception) from execute.

---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction-fetch front end. Owns the program counter, drives a word
//   address to a combinational instruction ROM and registers each fetched
//   word (with its PC) into a valid/ready output stage feeding decode.
//   Absolute jumps (j/jal) are resolved locally; execute may redirect the
//   PC at any time (branch, jr, exception).
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   imem_addr         ROM word address (always the pc register)
//   imem_instr        ROM data, combinational from imem_addr
//   redirect_valid    execute requests a PC change this cycle
//   redirect_target   new PC (low two bits forced to zero)
//   halt_req          stop fetching while high
//   id_ready          decode accepts the held word this cycle
//   if_valid          output register holds a word
//   if_instr          fetched instruction (nop if outside ROM range)
//   if_pc             address of if_instr
//   if_pc_plus4       if_pc + 4
//   addr_fault        sticky: out-of-range fetch or misaligned redirect
//   fetch_count       number of words accepted by decode (wraps)

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned COUNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  input  logic               halt_req,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4,
  output logic               addr_fault,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(IMEM_WORDS);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] fetched;
  logic [31:0] jump_pc;
  logic [31:0] redirect_pc;
  logic        in_range;
  logic        is_jump;
  logic        misaligned;
  logic        accept;
  logic        capture;

  // ROM address comes straight from the pc register, so there is no
  // combinational path from id_ready/redirect_valid to imem_addr.
  assign imem_addr = pc;

  always_comb begin
    pc_plus4    = pc + 32'd4;
    in_range    = pc[31:2] < WORD_LIMIT;
    // Out-of-range fetches are replaced by a nop, so they never decode as jumps.
    fetched     = in_range ? imem_instr : '0;
    // j = 000010, jal = 000011
    is_jump     = fetched[31:27] == 5'b00001;
    jump_pc     = {pc_plus4[31:28], fetched[25:0], 2'b00};
    redirect_pc = {redirect_target[31:2], 2'b00};
    misaligned  = redirect_target[1:0] != 2'b00;
    accept      = if_valid && id_ready;
    capture     = (state == RUN) && !halt_req && !redirect_valid &&
                  (!if_valid || id_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      addr_fault  <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT:    state <= halt_req ? HALT : RUN;
        RUN:     if (halt_req) state <= HALT;
        HALT:    if (!halt_req) state <= RUN;
        default: state <= BOOT;
      endcase

      if (redirect_valid)
        pc <= redirect_pc;
      else if (capture)
        pc <= is_jump ? jump_pc : pc_plus4;

      // A redirect never captures; the held word is dropped whether or not
      // decode took it this cycle (if it did, it is counted below).
      if (capture) begin
        if_valid    <= 1'b1;
        if_instr    <= fetched;
        if_pc       <= pc;
        if_pc_plus4 <= pc_plus4;
      end else if (accept || redirect_valid) begin
        if_valid <= 1'b0;
      end

      if (accept)
        fetch_count <= fetch_count + COUNT_W'(1);

      if ((redirect_valid && misaligned) || (capture && !in_range))
        addr_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit with a behavioural ROM. Expected
//   delivery addresses are queued as stimulus is applied; every decode
//   handshake pops the queue and checks pc, instruction and pc+4.

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        addr_fault;
  logic [31:0] fetch_count;

  logic [31:0] rom [256];
  logic [31:0] exp_q [$];
  logic [31:0] mon_pc;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  // Garbage outside the ROM so the nop substitution is observable.
  assign imem_instr = (imem_addr[31:10] == 22'd0) ? rom[imem_addr[9:2]] : 32'hDEAD_BEEF;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(256),
    .COUNT_W   (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .addr_fault     (addr_fault),
    .fetch_count    (fetch_count)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a[31:10] == 22'd0) ? rom[a[9:2]] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc_plus4, 32'd0);
    chk("rst_fault", {31'd0, addr_fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
  endtask

  // Handshakes are seen on the falling edge, ahead of the rising edge that
  // completes them.
  always @(negedge clk) begin
    if (!reset && if_valid && id_ready) begin
      chk("hs_expected_word", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_pc = exp_q.pop_front();
        chk("hs_pc", if_pc, mon_pc);
        chk("hs_instr", if_instr, rom_word(mon_pc));
        chk("hs_pc4", if_pc_plus4, mon_pc + 32'd4);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 | 32'(i);
    rom[0]  = 32'h0800_000E;
    rom[14] = 32'h2004_B42D;

    reset = 1'b1; id_ready = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    tick(); tick();
    chk_reset_state();

    // Boot, local jump from 0x0 to 0x38, then sequential fetch.
    exp_q.push_back(32'h00); exp_q.push_back(32'h38); exp_q.push_back(32'h3C);
    reset = 1'b0; id_ready = 1'b1;
    tick();
    chk("boot_no_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_instr", if_instr, 32'h0800_000E);
    chk("jump_addr", imem_addr, 32'h38);
    tick();
    chk("jt_pc", if_pc, 32'h38);
    chk("jt_instr", if_instr, 32'h2004_B42D);
    tick();
    chk("seq_pc", if_pc, 32'h3C);
    tick();
    id_ready = 1'b0;
    chk("stall_pc0", if_pc, 32'h40);
    chk("stall_addr0", imem_addr, 32'h44);
    chk("count3", fetch_count, 32'd3);
    chk("q_empty1", 32'(exp_q.size()), 32'd0);

    // Back-pressure: output and pc hold for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, 32'h40);
      chk("stall_instr", if_instr, rom[16]);
      chk("stall_addr", imem_addr, 32'h44);
      chk("stall_count", fetch_count, 32'd3);
    end
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    id_ready = 1'b1;
    tick();
    chk("release_pc", if_pc, 32'h44);
    tick();
    chk("release_pc2", if_pc, 32'h48);

    // Redirect while a word is held and not accepted: flushed.
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0C;
    tick();
    redirect_valid = 1'b0;
    chk("flush_valid", {31'd0, if_valid}, 32'd0);
    chk("flush_addr", imem_addr, 32'h0C);
    chk("flush_count", fetch_count, 32'd5);
    exp_q.push_back(32'h0C); exp_q.push_back(32'h10);
    id_ready = 1'b1;
    tick();
    chk("redir_pc", if_pc, 32'h0C);
    chk("redir_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_fault", {31'd0, addr_fault}, 32'd0);
    tick();
    chk("redir_pc2", if_pc, 32'h10);

    // Misaligned redirect with the held word accepted in the same cycle.
    redirect_valid = 1'b1; redirect_target = 32'h26;
    tick();
    redirect_valid = 1'b0; id_ready = 1'b0;
    chk("mis_addr", imem_addr, 32'h24);
    chk("mis_fault", {31'd0, addr_fault}, 32'd1);
    chk("mis_valid", {31'd0, if_valid}, 32'd0);
    chk("mis_count", fetch_count, 32'd7);
    tick();
    chk("mis_pc", if_pc, 32'h24);
    chk("mis_instr", if_instr, rom[9]);
    chk("mis_fault_sticky", {31'd0, addr_fault}, 32'd1);

    // Halt for four cycles: drain, redirect in HALT, resume at 0x10.
    halt_req = 1'b1;
    tick();
    chk("halt_hold_valid", {31'd0, if_valid}, 32'd1);
    chk("halt_hold_pc", if_pc, 32'h24);
    chk("halt_addr", imem_addr, 32'h28);
    exp_q.push_back(32'h24);
    id_ready = 1'b1;
    tick();
    chk("halt_drain_valid", {31'd0, if_valid}, 32'd0);
    chk("halt_drain_addr", imem_addr, 32'h28);
    chk("halt_count", fetch_count, 32'd8);
    redirect_valid = 1'b1; redirect_target = 32'h10;
    tick();
    redirect_valid = 1'b0;
    chk("halt_redir_addr", imem_addr, 32'h10);
    chk("halt_nocap1", {31'd0, if_valid}, 32'd0);
    tick();
    chk("halt_nocap2", {31'd0, if_valid}, 32'd0);
    chk("halt_redir_hold", imem_addr, 32'h10);
    halt_req = 1'b0; id_ready = 1'b0;
    tick();
    chk("resume_nocap", {31'd0, if_valid}, 32'd0);
    tick();
    chk("resume_valid", {31'd0, if_valid}, 32'd1);
    chk("resume_pc", if_pc, 32'h10);
    chk("fault_before_rst", {31'd0, addr_fault}, 32'd1);
    chk("q_empty2", 32'(exp_q.size()), 32'd0);

    // Reset while a word is held and stalled.
    reset = 1'b1;
    tick();
    chk_reset_state();

    // Redirect during BOOT to the last ROM word, then run past the end.
    reset = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h3FC; id_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("end_addr", imem_addr, 32'h3FC);
    chk("end_boot_valid", {31'd0, if_valid}, 32'd0);
    exp_q.push_back(32'h3FC);
    tick();
    chk("last_pc", if_pc, 32'h3FC);
    chk("last_instr", if_instr, rom[255]);
    chk("last_fault", {31'd0, addr_fault}, 32'd0);
    exp_q.push_back(32'h400);
    tick();
    chk("oob_pc", if_pc, 32'h400);
    chk("oob_instr", if_instr, 32'h0);
    chk("oob_pc4", if_pc_plus4, 32'h404);
    chk("oob_fault", {31'd0, addr_fault}, 32'd1);
    tick();
    id_ready = 1'b0;
    chk("oob_count", fetch_count, 32'd2);
    chk("oob_next_pc", if_pc, 32'h404);

    // PC wrap-around from 0xFFFF_FFFC to 0.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; id_ready = 1'b1;
    chk("wrap_flush", {31'd0, if_valid}, 32'd0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    tick();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    chk("wrap_instr", if_instr, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    tick();
    chk("wrap_word0_pc", if_pc, 32'h0);
    chk("wrap_jump_addr", imem_addr, 32'h38);
    tick();
    id_ready = 1'b0;
    chk("final_count", fetch_count, 32'd4);
    chk("final_pc", if_pc, 32'h38);
    chk("q_empty3", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
